// File: rtl/my_registers.sv
// Register-block layout shared by the component register reader and the
// per-component responders.
package my_registers;

  typedef struct packed {
    logic [15:0] component;
    logic [7:0]  major;
    logic [3:0]  minor;
    logic [3:0]  build;
  } version_register_t;

  // Word 1 occupies the upper half, word 0 (version) the lower half.
  typedef struct packed {
    logic [15:0]       memory_offset;
    logic [7:0]        stat_depth;
    logic [7:0]        stat_width;
    version_register_t version;
  } component_registers_t;

  localparam int VERSION_OFFSET = 0;
  localparam int CONFIG_OFFSET  = 4;

  localparam component_registers_t DEFAULT_READ_MASK = '{
    memory_offset: 16'hFFFF,
    stat_depth:    8'hFF,
    stat_width:    8'hFF,
    version:       '{component: 16'hFFFF, major: 8'hFF, minor: 4'hF, build: 4'hF}
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RSP,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/component_register_reader.sv
// Bus initiator that sweeps a component's two-word register block, masks the
// result and checks the version's component ID.
module component_register_reader
  import my_registers::*;
#(
  parameter int                   ADDR_WIDTH         = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR         = '0,
  parameter component_registers_t READ_MASK          = DEFAULT_READ_MASK,
  parameter logic [15:0]          EXPECTED_COMPONENT = 16'h0000,
  parameter int                   TIMEOUT_CYCLES     = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  version_mismatch,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  rsp_valid,
  input  logic [31:0]           rsp_data,
  input  logic                  rsp_error,
  output logic [63:0]           regs_out,
  output logic                  regs_valid
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  state_t               state;
  logic                 idx;
  logic [31:0]          word0;
  logic [CNT_W-1:0]     cnt;
  logic                 expired;
  component_registers_t masked;

  // Counter holds cycles already spent in the state, so expiry fires on the
  // TIMEOUT_CYCLES-th cycle.
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign masked  = component_registers_t'({rsp_data, word0}) & READ_MASK;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      idx              <= 1'b0;
      word0            <= '0;
      cnt              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      version_mismatch <= 1'b0;
      req_valid        <= 1'b0;
      req_addr         <= '0;
      regs_out         <= '0;
      regs_valid       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state            <= ST_REQ;
            idx              <= 1'b0;
            cnt              <= '0;
            error            <= 1'b0;
            version_mismatch <= 1'b0;
            regs_valid       <= 1'b0;
            busy             <= 1'b1;
            req_valid        <= 1'b1;
            req_addr         <= BASE_ADDR + ADDR_WIDTH'(VERSION_OFFSET);
          end
        end
        ST_REQ: begin
          // An accepted request wins over a simultaneous expiry.
          if (req_ready) begin
            state     <= ST_WAIT_RSP;
            req_valid <= 1'b0;
            cnt       <= '0;
          end else if (expired) begin
            state     <= ST_FINISH;
            error     <= 1'b1;
            req_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_RSP: begin
          if (rsp_valid && !rsp_error) begin
            if (idx) begin
              state            <= ST_FINISH;
              regs_out         <= masked;
              regs_valid       <= 1'b1;
              version_mismatch <= (masked.version.component != EXPECTED_COMPONENT);
              busy             <= 1'b0;
              done             <= 1'b1;
            end else begin
              state     <= ST_REQ;
              word0     <= rsp_data;
              idx       <= 1'b1;
              cnt       <= '0;
              req_valid <= 1'b1;
              req_addr  <= BASE_ADDR + ADDR_WIDTH'(CONFIG_OFFSET);
            end
          end else if (rsp_valid || expired) begin
            state <= ST_FINISH;
            error <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule
